// File: rtl/ev_input_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module   : ev_input_conditioner_if
//  Purpose  : Bundles the raw button inputs and the conditioned level/pulse
//             outputs of ev_input_conditioner.
//  Signals  : btn_inc, btn_dec          raw buttons (pad side -> conditioner)
//             inc_level, dec_level      debounced levels
//             inc_pulse, dec_pulse      one-cycle count requests
//             conflict                  one-cycle collision flag
//  Modports : master = pad/stimulus side, slave = conditioner
//  Revision : 1.0  initial release
// ============================================================================
interface ev_input_conditioner_if;
    logic btn_inc;
    logic btn_dec;
    logic inc_level;
    logic dec_level;
    logic inc_pulse;
    logic dec_pulse;
    logic conflict;

    modport master (
        output btn_inc, btn_dec,
        input  inc_level, dec_level, inc_pulse, dec_pulse, conflict
    );

    modport slave (
        input  btn_inc, btn_dec,
        output inc_level, dec_level, inc_pulse, dec_pulse, conflict
    );
endinterface
`default_nettype wire

// File: rtl/ev_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : ev_input_conditioner
//  Purpose  : Synchronises and debounces the increment/decrement buttons and
//             turns debounced presses into single-cycle count requests, with
//             collision arbitration between the two channels.
//  Ports    : clk    - clock, all state on rising edge
//             rst    - asynchronous active-high reset
//             bus    - ev_input_conditioner_if.slave (buttons in; levels,
//                      pulses and conflict out)
//  Params   : DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD
//  Macro    : EV_AUTOREPEAT_EN - when defined, a held press auto-repeats
//             (REPEAT state + 16-bit hold timer); otherwise one pulse per press.
//  Revision : 1.0  initial release
// ============================================================================
module ev_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    ev_input_conditioner_if.slave bus
);

    localparam int                 c_CNT_W   = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef EV_AUTOREPEAT_EN
    localparam logic [15:0] c_DELAY_LAST  = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] c_PERIOD_LAST = 16'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1
    } state_t;

    // Repeat parameters have no effect in this build.
    logic w_repeat_cfg_unused;
    assign w_repeat_cfg_unused = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    // Channel 0 = increment, channel 1 = decrement.
    logic [1:0] w_raw;
    logic [1:0] w_level;
    logic [1:0] w_req;

    assign w_raw = {bus.btn_dec, bus.btn_inc};

    for (genvar g = 0; g < 2; g++) begin : g_chan
        logic               r_s1;
        logic               r_s2;
        logic               r_level;
        logic [c_CNT_W-1:0] r_cnt;
        logic               w_flip;
        logic               w_rise;
        logic               w_fall;
        logic               w_req_ch;
        state_t             r_state;
        state_t             w_state_nxt;
`ifdef EV_AUTOREPEAT_EN
        logic [15:0]        r_timer;
        logic               w_tmr_clr;
`endif

        // Synchroniser and integrating debounce: any cycle where s2 agrees
        // with the current level discards all accumulated credit.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_s1    <= 1'b0;
                r_s2    <= 1'b0;
                r_level <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_s1 <= w_raw[g];
                r_s2 <= r_s1;
                if (r_s2 == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    r_cnt   <= '0;
                    r_level <= ~r_level;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        // Level-change events are decoded one cycle early so the FSM and
        // the pulse register update on the same edge as the level itself.
        assign w_flip = (r_s2 != r_level) && (r_cnt == c_CNT_MAX);
        assign w_rise = w_flip && !r_level;
        assign w_fall = w_flip &&  r_level;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= ST_IDLE;
            end else begin
                r_state <= w_state_nxt;
            end
        end

        // A release takes priority over a coincident repeat so that a
        // release can never produce a request.
        always_comb begin
            w_state_nxt = r_state;
            w_req_ch    = 1'b0;
`ifdef EV_AUTOREPEAT_EN
            w_tmr_clr   = 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_rise) begin
                        w_state_nxt = ST_HELD;
                        w_req_ch    = 1'b1;
                    end
                end
                ST_HELD: begin
                    if (w_fall) begin
                        w_state_nxt = ST_IDLE;
`ifdef EV_AUTOREPEAT_EN
                    end else if (r_timer == c_DELAY_LAST) begin
                        w_state_nxt = ST_REPEAT;
                        w_req_ch    = 1'b1;
`endif
                    end
                end
`ifdef EV_AUTOREPEAT_EN
                ST_REPEAT: begin
                    if (w_fall) begin
                        w_state_nxt = ST_IDLE;
                    end else if (r_timer == c_PERIOD_LAST) begin
                        w_req_ch  = 1'b1;
                        w_tmr_clr = 1'b1;
                    end
                end
`endif
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

`ifdef EV_AUTOREPEAT_EN
        // Hold timer: restarts on every state change or repeat, saturates.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_timer <= '0;
            end else if ((w_state_nxt != r_state) || w_tmr_clr) begin
                r_timer <= '0;
            end else if ((r_state != ST_IDLE) && (r_timer != 16'hFFFF)) begin
                r_timer <= r_timer + 16'd1;
            end
        end
`endif

        assign w_level[g] = r_level;
        assign w_req[g]   = w_req_ch;
    end

    // Arbitration: simultaneous requests cancel each other and flag conflict.
    logic r_inc_pulse;
    logic r_dec_pulse;
    logic r_conflict;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inc_pulse <= 1'b0;
            r_dec_pulse <= 1'b0;
            r_conflict  <= 1'b0;
        end else begin
            r_inc_pulse <= w_req[0] & ~w_req[1];
            r_dec_pulse <= w_req[1] & ~w_req[0];
            r_conflict  <= w_req[0] &  w_req[1];
        end
    end

    assign bus.inc_level = w_level[0];
    assign bus.dec_level = w_level[1];
    assign bus.inc_pulse = r_inc_pulse;
    assign bus.dec_pulse = r_dec_pulse;
    assign bus.conflict  = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_ev_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ev_input_conditioner
//  Purpose  : Directed self-checking bench for ev_input_conditioner with
//             DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3. Expected
//             values follow the autorepeat build when EV_AUTOREPEAT_EN is set.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ev_input_conditioner;

`ifdef EV_AUTOREPEAT_EN
    localparam bit c_AUTO = 1'b1;
`else
    localparam bit c_AUTO = 1'b0;
`endif

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    ev_input_conditioner_if bus ();

    ev_input_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (8),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance n edges and count the pulses observed after each edge.
    task automatic watch(input int n, output int ni, output int nd, output int nc);
        ni = 0; nd = 0; nc = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            ni += int'(bus.inc_pulse === 1'b1);
            nd += int'(bus.dec_pulse === 1'b1);
            nc += int'(bus.conflict  === 1'b1);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_inc_level"}, int'(bus.inc_level), 0);
        chk({tag, "_dec_level"}, int'(bus.dec_level), 0);
        chk({tag, "_inc_pulse"}, int'(bus.inc_pulse), 0);
        chk({tag, "_dec_pulse"}, int'(bus.dec_pulse), 0);
        chk({tag, "_conflict"},  int'(bus.conflict),  0);
    endtask

    initial begin
        int ni, nd, nc;
        errors = 0;
        checks = 0;

        // ---------------- reset with buttons held ----------------
        rst = 1'b1;
        bus.btn_inc = 1'b1;
        bus.btn_dec = 1'b1;
        ticks(4);
        chk_all_zero("reset");
        bus.btn_dec = 1'b0;          // only inc held across reset release
        ticks(3);
        rst = 1'b0;                  // just after edge j
        ticks(5);                    // edge j+5
        chk("rst_rel_level_j5", int'(bus.inc_level), 0);
        chk("rst_rel_pulse_j5", int'(bus.inc_pulse), 0);
        tick();                      // edge j+6
        chk("rst_rel_level_j6", int'(bus.inc_level), 1);
        chk("rst_rel_pulse_j6", int'(bus.inc_pulse), 1);
        bus.btn_inc = 1'b0;
        watch(8, ni, nd, nc);
        chk("rst_rel_release_pulses", ni + nd + nc, 0);
        chk("rst_rel_released_level", int'(bus.inc_level), 0);

        // ---------------- bounce ----------------
        bus.btn_inc = 1'b1; tick();
        bus.btn_inc = 1'b0; tick();
        bus.btn_inc = 1'b1; tick();
        bus.btn_inc = 1'b0;
        watch(10, ni, nd, nc);
        chk("bounce_pulses", ni + nd + nc, 0);
        chk("bounce_level", int'(bus.inc_level), 0);
        bus.btn_inc = 1'b1;          // first stable-high sample at next edge k
        ticks(5);                    // edge k+4
        chk("bounce_press_level_k4", int'(bus.inc_level), 0);
        tick();                      // edge k+5 = P
        chk("bounce_press_level_k5", int'(bus.inc_level), 1);
        chk("bounce_press_pulse_k5", int'(bus.inc_pulse), 1);
        bus.btn_inc = 1'b0;          // level falls at P+6, before any repeat
        watch(10, ni, nd, nc);
        chk("bounce_single_pulse", ni, 0);

        // ---------------- dec press and release ----------------
        bus.btn_dec = 1'b1;
        ticks(6);                    // P
        chk("dec_press_level", int'(bus.dec_level), 1);
        chk("dec_press_pulse", int'(bus.dec_pulse), 1);
        bus.btn_dec = 1'b0;
        watch(5, ni, nd, nc);        // P+1..P+5
        chk("dec_release_no_pulse", nd, 0);
        chk("dec_release_level_p5", int'(bus.dec_level), 1);
        tick();                      // P+6
        chk("dec_release_level_p6", int'(bus.dec_level), 0);
        chk("dec_release_pulse_p6", int'(bus.dec_pulse), 0);
        ticks(4);

        // ---------------- collision ----------------
        bus.btn_inc = 1'b1;
        bus.btn_dec = 1'b1;
        ticks(6);                    // P
        chk("coll_conflict",  int'(bus.conflict),  1);
        chk("coll_inc_pulse", int'(bus.inc_pulse), 0);
        chk("coll_dec_pulse", int'(bus.dec_pulse), 0);
        tick();                      // P+1
        chk("coll_conflict_once", int'(bus.conflict), 0);
        bus.btn_dec = 1'b0;          // dec level falls at P+7
        watch(6, ni, nd, nc);        // P+2..P+7
        chk("coll_quiet_pulses", ni + nd + nc, 0);
        chk("coll_dec_level_fell", int'(bus.dec_level), 0);
        tick();                      // P+8
        chk("coll_inc_first_repeat", int'(bus.inc_pulse), c_AUTO ? 1 : 0);
        watch(12, ni, nd, nc);       // P+9..P+20: repeats at 11,14,17,20
        chk("coll_inc_repeats", ni, c_AUTO ? 4 : 0);
        chk("coll_no_dec_or_conflict", nd + nc, 0);
        bus.btn_inc = 1'b0;          // sampled P+21, falls P+26, repeat at 23
        watch(7, ni, nd, nc);
        chk("coll_release_tail", ni, c_AUTO ? 1 : 0);
        watch(8, ni, nd, nc);
        chk("coll_after_release", ni + nd + nc, 0);

        // ---------------- long hold ----------------
        bus.btn_inc = 1'b1;
        ticks(6);                    // P
        chk("hold_press_pulse", int'(bus.inc_pulse), 1);
        for (int i = 1; i <= 30; i++) begin
            tick();
            chk($sformatf("hold_p%0d", i), int'(bus.inc_pulse),
                (c_AUTO && i >= 8 && ((i - 8) % 3) == 0) ? 1 : 0);
        end
        bus.btn_inc = 1'b0;          // sampled P+31, falls P+36; repeats 32,35
        watch(10, ni, nd, nc);
        chk("hold_release_tail", ni, c_AUTO ? 2 : 0);
        chk("hold_released_level", int'(bus.inc_level), 0);
        watch(10, ni, nd, nc);
        chk("hold_after_release", ni + nd + nc, 0);

        // ---------------- async reset mid-repeat ----------------
        bus.btn_inc = 1'b1;
        ticks(6);                    // P
        chk("areset_press_pulse", int'(bus.inc_pulse), 1);
        ticks(9);                    // P+9, between repeats at 8 and 11
        chk("areset_level_before", int'(bus.inc_level), 1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("areset_immediate");
        ticks(2);
        chk_all_zero("areset_held");
        rst = 1'b0;                  // just after edge j, button still held
        ticks(5);                    // j+5
        chk("areset_rel_level_j5", int'(bus.inc_level), 0);
        tick();                      // j+6
        chk("areset_rel_level_j6", int'(bus.inc_level), 1);
        chk("areset_rel_pulse_j6", int'(bus.inc_pulse), 1);
        bus.btn_inc = 1'b0;
        ticks(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
